// File: rtl/alu_mult_sequencer.sv
// ============================================================================
//  Module      : alu_mult_sequencer
//  Description : Shift-and-add 32x32 -> 32 (low word) unsigned multiplier
//                sequencer. It owns no accumulator adder. Every partial-sum
//                addition is issued to an external combinational ALU through
//                SrcA/SrcB/ALUControl, and the sum comes back on ALUResult.
//
//  Ports
//    clk          in   1   clock, rising edge
//    reset        in   1   synchronous, active-high
//    Start        in   1   start request (accepted in IDLE or DONE)
//    Multiplicand in  32   operand A, captured on the accepting edge
//    Multiplier   in  32   operand B, captured on the accepting edge
//    Busy         out  1   high while in RUN
//    Done         out  1   one-cycle completion pulse (DONE state)
//    Product      out 32   low 32 bits of A*B, held until the next completion
//    SrcA         out 32   ALU operand A
//    SrcB         out 32   ALU operand B
//    ALUControl   out  3   ALU opcode (010 = ADD while in RUN, else 000)
//    ALUResult    in  32   combinational ALU result
//    ZeroFlag     in   1   ALU zero flag, not used by this block
//
//  Parameter
//    EARLY_EXIT   1: stop once the remaining multiplier bits are all zero
//                 0: always run 32 steps
//
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_mult_sequencer #(
    parameter int EARLY_EXIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [31:0] Multiplicand,
    input  logic [31:0] Multiplier,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Product,
    output logic [31:0] SrcA,
    output logic [31:0] SrcB,
    output logic [2:0]  ALUControl,
    input  logic [31:0] ALUResult,
    input  logic        ZeroFlag
);

    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_add = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [4:0]  r_count;
    logic [31:0] r_product;
    logic        w_last_step;

    // The zero flag carries no information the sequencer needs.
    logic        w_unused_zeroflag;
    assign w_unused_zeroflag = ZeroFlag;

    // Final step: 32nd iteration, or (early exit) no set bits remain above
    // the one being consumed this cycle.
    assign w_last_step = (r_count == 5'd31) ||
                         ((EARLY_EXIT != 0) && (r_mplier[31:1] == 31'd0));

    // ------------------------------------------------------------------
    // Next-state and ALU drive
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        SrcA        = 32'h0;
        SrcB        = 32'h0;
        ALUControl  = c_alu_and;
        case (r_state)
            ST_IDLE: begin
                if (Start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                SrcA       = r_acc;
                SrcB       = r_mplier[0] ? r_mcand : 32'h0;
                ALUControl = c_alu_add;
                if (w_last_step) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = Start ? ST_RUN : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_mcand   <= 32'h0;
            r_mplier  <= 32'h0;
            r_acc     <= 32'h0;
            r_count   <= 5'd0;
            r_product <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        r_mcand  <= Multiplicand;
                        r_mplier <= Multiplier;
                        r_acc    <= 32'h0;
                        r_count  <= 5'd0;
                    end
                end
                ST_RUN: begin
                    // Accumulation comes back from the external ALU.
                    r_acc    <= ALUResult;
                    r_mcand  <= {r_mcand[30:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[31:1]};
                    r_count  <= r_count + 5'd1;
                    if (w_last_step) r_product <= ALUResult;
                end
                default: ;
            endcase
        end
    end

    assign Busy    = (r_state == ST_RUN);
    assign Done    = (r_state == ST_DONE);
    assign Product = r_product;

endmodule

`default_nettype wire
